// File: rtl/cmp_pkg.sv
// Shared definitions for comparator-flag consumers: flag bit positions,
// window FSM states, majority codes and the majority helper.
package cmp_pkg;

  localparam int EQ  = 5;
  localparam int NEQ = 4;
  localparam int GT  = 3;
  localparam int LT  = 2;
  localparam int GE  = 1;
  localparam int LE  = 0;

  // Widest counter value ever needed (WINDOW tops out at 255)
  localparam int CNT_MAX_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    REPORT  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MAJ_NONE = 2'b00,
    MAJ_GT   = 2'b01,
    MAJ_LT   = 2'b10,
    MAJ_EQ   = 2'b11
  } maj_t;

  // Strict winner only; any tie for the top value (including all zero) is none
  function automatic maj_t majority_of(input logic [CNT_MAX_W-1:0] g,
                                       input logic [CNT_MAX_W-1:0] l,
                                       input logic [CNT_MAX_W-1:0] e);
    if (g > l && g > e)      return MAJ_GT;
    else if (l > g && l > e) return MAJ_LT;
    else if (e > g && e > l) return MAJ_EQ;
    else                     return MAJ_NONE;
  endfunction

endpackage

// File: rtl/cmp_flag_check.sv
// Combinational sanity check of a comparator flag vector: exactly one relation
// holds and the derived flags (neq, ge, le) agree with it.
module cmp_flag_check
  import cmp_pkg::*;
(
  input  logic [5:0] flags_in,
  output logic       consistent
);

  logic eq, neq, gt, lt, ge, le;

  assign eq  = flags_in[EQ];
  assign neq = flags_in[NEQ];
  assign gt  = flags_in[GT];
  assign lt  = flags_in[LT];
  assign ge  = flags_in[GE];
  assign le  = flags_in[LE];

  assign consistent = $onehot({eq, gt, lt}) &&
                      (neq == !eq) &&
                      (ge == (gt | eq)) &&
                      (le == (lt | eq));

endmodule

// File: rtl/compare_window_stats.sv
// Collects WINDOW comparator samples after a start request, tallies gt/lt/eq
// relations and flag errors, then holds the result until the consumer takes it.
module compare_window_stats
  import cmp_pkg::*;
#(
  parameter  int WINDOW = 8,
  localparam int CW     = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [5:0]    flags_in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          start,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [CW-1:0] gt_count,
  output logic [CW-1:0] lt_count,
  output logic [CW-1:0] eq_count,
  output logic [1:0]    majority,
  output logic          flags_err
);

  state_t        state;
  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] gt_next, lt_next, eq_next;
  logic          consistent;
  logic          accept;
  logic          last_sample;

  cmp_flag_check u_flag_check (
    .flags_in   (flags_in),
    .consistent (consistent)
  );

  assign in_ready    = (state == COLLECT);
  assign out_valid   = (state == REPORT);
  assign accept      = in_valid && in_ready;
  assign last_sample = (sample_cnt == CW'(WINDOW - 1));

  // Inconsistent vectors still occupy a window slot but add to no relation
  always_comb begin
    gt_next = gt_count + CW'(consistent & flags_in[GT]);
    lt_next = lt_count + CW'(consistent & flags_in[LT]);
    eq_next = eq_count + CW'(consistent & flags_in[EQ]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      gt_count   <= '0;
      lt_count   <= '0;
      eq_count   <= '0;
      majority   <= MAJ_NONE;
      flags_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= COLLECT;
            sample_cnt <= '0;
            gt_count   <= '0;
            lt_count   <= '0;
            eq_count   <= '0;
            majority   <= MAJ_NONE;
            flags_err  <= 1'b0;
          end
        end
        COLLECT: begin
          if (accept) begin
            sample_cnt <= sample_cnt + CW'(1);
            gt_count   <= gt_next;
            lt_count   <= lt_next;
            eq_count   <= eq_next;
            majority   <= majority_of(CNT_MAX_W'(gt_next), CNT_MAX_W'(lt_next),
                                      CNT_MAX_W'(eq_next));
            if (!consistent) flags_err <= 1'b1;
            if (last_sample) state <= REPORT;
          end
        end
        REPORT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compare_window_stats.sv
// Randomized scoreboard bench for compare_window_stats (WINDOW=4) with a
// window-level reference model and directed reset/backpressure scenarios.
module tb_compare_window_stats;

  localparam int WINDOW = 4;
  localparam int CW     = $clog2(WINDOW + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    flags_in;
  logic          in_valid;
  logic          in_ready;
  logic          start;
  logic          out_ready;
  logic          out_valid;
  logic [CW-1:0] gt_count, lt_count, eq_count;
  logic [1:0]    majority;
  logic          flags_err;

  typedef struct {
    int gt;
    int lt;
    int eq;
    int maj;
    int err;
  } exp_t;

  exp_t       expQ[$];
  exp_t       lastExp;
  logic [5:0] win[$];
  int         tests    = 0;
  int         failures = 0;

  compare_window_stats #(.WINDOW(WINDOW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flags_in  (flags_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .start     (start),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .gt_count  (gt_count),
    .lt_count  (lt_count),
    .eq_count  (eq_count),
    .majority  (majority),
    .flags_err (flags_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Only three flag vectors describe a real relation: A>B, A<B, A==B
  function automatic exp_t modelWindow(input logic [5:0] s[$]);
    exp_t r;
    int   mx, ties;
    r = '{0, 0, 0, 0, 0};
    foreach (s[i]) begin
      case (s[i])
        6'h1A:   r.gt++;
        6'h15:   r.lt++;
        6'h23:   r.eq++;
        default: r.err = 1;
      endcase
    end
    mx   = (r.gt > r.lt) ? r.gt : r.lt;
    mx   = (r.eq > mx) ? r.eq : mx;
    ties = int'(r.gt == mx) + int'(r.lt == mx) + int'(r.eq == mx);
    if (mx == 0 || ties > 1) r.maj = 0;
    else if (r.gt == mx)     r.maj = 1;
    else if (r.lt == mx)     r.maj = 2;
    else                     r.maj = 3;
    return r;
  endfunction

  task automatic checkResult(input string tag, input exp_t e);
    checkOutput({tag, "_gt"},  32'(gt_count),  32'(e.gt));
    checkOutput({tag, "_lt"},  32'(lt_count),  32'(e.lt));
    checkOutput({tag, "_eq"},  32'(eq_count),  32'(e.eq));
    checkOutput({tag, "_maj"}, 32'(majority),  32'(e.maj));
    checkOutput({tag, "_err"}, 32'(flags_err), 32'(e.err));
  endtask

  // Monitor: every completed handshake must match the oldest expected window
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checkOutput("result_expected", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) checkResult("result", expQ.pop_front());
    end
  end

  task automatic doStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    win.delete();
  endtask

  // One sample after `gap` idle cycles; optionally pulses start alongside it
  task automatic applyStimulus(input logic [5:0] f, input int gap, input bit pulseStart);
    exp_t e;
    repeat (gap) begin
      in_valid = 1'b0;
      flags_in = 6'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    flags_in = f;
    start    = pulseStart;
    win.push_back(f);
    @(negedge clk);
    checkOutput("collect_in_ready", 32'(in_ready), 32'd1);
    checkOutput("collect_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
    if (win.size() == WINDOW) begin
      e       = modelWindow(win);
      lastExp = e;
      expQ.push_back(e);
      win.delete();
      @(negedge clk);
      checkOutput("valid_after_last", 32'(out_valid), 32'd1);
      checkOutput("ready_after_last", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // Hold the result for `hold` extra cycles with noise on the ignored inputs
  task automatic releaseResult(input int hold);
    out_ready = 1'b0;
    repeat (hold) begin
      in_valid = 1'($urandom);
      flags_in = 6'($urandom);
      start    = 1'($urandom);
      @(negedge clk);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkResult("hold", lastExp);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [5:0] randFlags();
    case ($urandom_range(0, 4))
      0:       return 6'h1A;
      1:       return 6'h15;
      2:       return 6'h23;
      3:       return 6'($urandom);
      default: return 6'h1A;
    endcase
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    logic [5:0] s1[4] = '{6'h1A, 6'h1A, 6'h15, 6'h1A};
    logic [5:0] s2[4] = '{6'h23, 6'h15, 6'h23, 6'h15};
    logic [5:0] s3[4] = '{6'h23, 6'h3F, 6'h23, 6'h23};

    rst_n     = 1'b0;
    flags_in  = '0;
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    #12;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkResult("reset", '{0, 0, 0, 0, 0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Samples offered while idle must not reach any window
    repeat (3) begin
      in_valid = 1'b1;
      flags_in = 6'h23;
      @(negedge clk);
      checkOutput("idle_ignores_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    doStart();
    for (int i = 0; i < WINDOW; i++) applyStimulus(s1[i], 0, i == 1);
    releaseResult(0);

    doStart();
    for (int i = 0; i < WINDOW; i++) applyStimulus(s2[i], 1, 1'b0);
    releaseResult(5);

    doStart();
    for (int i = 0; i < WINDOW; i++) applyStimulus(s3[i], i % 2, 1'b0);
    releaseResult(2);

    // Reset in the middle of a window discards it asynchronously
    doStart();
    applyStimulus(6'h1A, 0, 1'b0);
    applyStimulus(6'h3F, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkResult("midreset", '{0, 0, 0, 0, 0});
    win.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < WINDOW; i++) applyStimulus(6'h15, 0, 1'b0);
    releaseResult(1);

    for (int w = 0; w < 8; w++) begin
      doStart();
      for (int i = 0; i < WINDOW; i++)
        applyStimulus(randFlags(), $urandom_range(0, 2), 1'($urandom));
      releaseResult($urandom_range(0, 3));
    end

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
